// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber butterfly datapath.
//   Q, W               default modulus and coefficient width
//   bf_mode_e          butterfly operation selector (CT, GS, GS_HALF, BYPASS)
//   barrett_m()        floor(2^(2*w) / q), the Barrett multiplier
//   BARRETT_K/M, INV2  derived constants for the default Q/W
package kyber_pkg;

    localparam int unsigned Q = 3329;
    localparam int unsigned W = 12;

    typedef enum logic [1:0] {
        ModeCt     = 2'd0,
        ModeGs     = 2'd1,
        ModeGsHalf = 2'd2,
        ModeBypass = 2'd3
    } bf_mode_e;

    function automatic int unsigned barrett_m(input int unsigned q, input int unsigned w);
        longint unsigned num;
        num = 64'd1 << (2 * w);
        return 32'(num / 64'(q));
    endfunction

    localparam int unsigned BARRETT_K = 2 * W;
    localparam int unsigned BARRETT_M = barrett_m(Q, W);
    localparam int unsigned INV2      = (Q + 1) / 2;

endpackage

// File: rtl/kyber_mod_mul_q.sv
// Combinational Barrett reduction of a product x < Q^2 to a canonical residue.
//   x  in   2*W  product to reduce
//   r  out  W    x mod Q, in [0, Q-1]
module kyber_mod_mul_q #(
    parameter int unsigned Q = kyber_pkg::Q,
    parameter int unsigned W = kyber_pkg::W
) (
    input  logic [2*W-1:0] x,
    output logic [W-1:0]   r
);
    import kyber_pkg::*;

    localparam int unsigned    K  = 2 * W;
    localparam logic [4*W-1:0] MW = (4 * W)'(barrett_m(Q, W));

    logic [4*W-1:0] prod;
    logic [W-1:0]   quot;
    logic [2*W-1:0] qq;
    logic [2*W-1:0] rr;
    logic [W:0]     r1;

    // quot underestimates x/Q by at most one, so rr < 2Q and one subtract suffices.
    always_comb begin
        prod = {{(2 * W){1'b0}}, x} * MW;
        quot = W'(prod >> K);
        qq   = {{W{1'b0}}, quot} * (2 * W)'(Q);
        rr   = x - qq;
        r1   = (W + 1)'(rr);
        r    = (r1 >= (W + 1)'(Q)) ? W'(r1 - (W + 1)'(Q)) : W'(r1);
    end

endmodule

// File: rtl/kyber_bf_unit.sv
// Pipelined multi-lane Kyber butterfly (CT forward, GS inverse, GS with halving,
// bypass) with a valid/ready handshake and full backpressure. Latency 3 cycles.
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      input handshake; mode, a_in, b_in, zeta_in sampled on accept
//   out_valid/out_ready    output handshake; a_out, b_out held while stalled
//   mode_err               sticky, set when a BYPASS (mode=3) beat is accepted
module kyber_bf_unit #(
    parameter int unsigned Q     = kyber_pkg::Q,
    parameter int unsigned W     = kyber_pkg::W,
    parameter int unsigned LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [LANES*W-1:0] a_in,
    input  logic [LANES*W-1:0] b_in,
    input  logic [LANES*W-1:0] zeta_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] a_out,
    output logic [LANES*W-1:0] b_out,
    output logic               mode_err
);
    import kyber_pkg::*;

    localparam logic [W-1:0] QW = W'(Q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, QW}) s = s - {1'b0, QW};
        return W'(s);
    endfunction

    // Wraps modulo 2^W, which is harmless because the true result is below Q.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        if (x < y) d = d + QW;
        return d;
    endfunction

    // Multiply by 2^-1 mod Q: odd values are made even by adding the (odd) modulus.
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
        logic [W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, QW}) : {1'b0, x};
        return W'(t >> 1);
    endfunction

    logic     adv, accept;
    bf_mode_e in_mode;

    logic     s1_valid_q, s2_valid_q, out_valid_q;
    bf_mode_e s1_mode_q, s2_mode_q;
    logic     mode_err_q;

    logic [W-1:0]   s1_a_d [LANES];
    logic [W-1:0]   s1_b_d [LANES];
    logic [W-1:0]   s1_a_q [LANES];
    logic [W-1:0]   s1_b_q [LANES];
    logic [W-1:0]   s1_z_q [LANES];
    logic [W-1:0]   s2_a_q [LANES];
    logic [W-1:0]   s2_b_q [LANES];
    logic [2*W-1:0] s2_p_q [LANES];
    logic [W-1:0]   red    [LANES];
    logic [W-1:0]   s3_a_d [LANES];
    logic [W-1:0]   s3_b_d [LANES];

    logic [LANES*W-1:0] a_out_q, b_out_q;

    assign adv       = out_ready | ~out_valid_q;
    assign in_ready  = adv;
    assign accept    = in_valid & adv;
    assign in_mode   = bf_mode_e'(mode);
    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign mode_err  = mode_err_q;

    // S1 front end: GS modes turn (a, b) into (a+b, a-b) before the multiply.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_a_d[i] = a_in[i*W +: W];
            s1_b_d[i] = b_in[i*W +: W];
            if (in_mode == ModeGs || in_mode == ModeGsHalf) begin
                s1_a_d[i] = add_mod(a_in[i*W +: W], b_in[i*W +: W]);
                s1_b_d[i] = sub_mod(a_in[i*W +: W], b_in[i*W +: W]);
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        kyber_mod_mul_q #(
            .Q(Q),
            .W(W)
        ) u_red (
            .x(s2_p_q[gi]),
            .r(red[gi])
        );
    end

    // S3 back end: red is b*zeta (CT) or (a-b)*zeta (GS) reduced mod Q.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s3_a_d[i] = s2_a_q[i];
            s3_b_d[i] = s2_b_q[i];
            unique case (s2_mode_q)
                ModeCt: begin
                    s3_a_d[i] = add_mod(s2_a_q[i], red[i]);
                    s3_b_d[i] = sub_mod(s2_a_q[i], red[i]);
                end
                ModeGs: begin
                    s3_a_d[i] = s2_a_q[i];
                    s3_b_d[i] = red[i];
                end
                ModeGsHalf: begin
                    s3_a_d[i] = half_mod(s2_a_q[i]);
                    s3_b_d[i] = half_mod(red[i]);
                end
                ModeBypass: begin
                    s3_a_d[i] = s2_a_q[i];
                    s3_b_d[i] = s2_b_q[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_mode_q   <= ModeCt;
            s2_mode_q   <= ModeCt;
            mode_err_q  <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_a_q[i] <= '0;
                s1_b_q[i] <= '0;
                s1_z_q[i] <= '0;
                s2_a_q[i] <= '0;
                s2_b_q[i] <= '0;
                s2_p_q[i] <= '0;
            end
        end else begin
            if (accept && in_mode == ModeBypass) mode_err_q <= 1'b1;
            // The whole pipe moves as one; a stalled output freezes every stage.
            if (adv) begin
                s1_valid_q  <= in_valid;
                s2_valid_q  <= s1_valid_q;
                out_valid_q <= s2_valid_q;
                if (in_valid) begin
                    s1_mode_q <= in_mode;
                    for (int i = 0; i < LANES; i++) begin
                        s1_a_q[i] <= s1_a_d[i];
                        s1_b_q[i] <= s1_b_d[i];
                        s1_z_q[i] <= zeta_in[i*W +: W];
                    end
                end
                if (s1_valid_q) begin
                    s2_mode_q <= s1_mode_q;
                    for (int i = 0; i < LANES; i++) begin
                        s2_a_q[i] <= s1_a_q[i];
                        s2_b_q[i] <= s1_b_q[i];
                        s2_p_q[i] <= {{W{1'b0}}, s1_b_q[i]} * {{W{1'b0}}, s1_z_q[i]};
                    end
                end
                if (s2_valid_q) begin
                    for (int i = 0; i < LANES; i++) begin
                        a_out_q[i*W +: W] <= s3_a_d[i];
                        b_out_q[i*W +: W] <= s3_b_d[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kyber_bf_unit.sv
// Directed bench for kyber_bf_unit: single-beat math, wrap cases, backpressure,
// full-rate streaming against a reference model, a 4-lane build, mode 3 and reset.
module tb_kyber_bf_unit;

    localparam int Q = 3329;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, mode_err;
    logic [1:0]   mode;
    logic [W-1:0] a_in, b_in, zeta_in, a_out, b_out;

    logic           in_valid4, in_ready4, out_valid4, out_ready4, mode_err4;
    logic [1:0]     mode4;
    logic [4*W-1:0] a_in4, b_in4, zeta_in4, a_out4, b_out4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    kyber_bf_unit #(.Q(Q), .W(W), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a_in(a_in), .b_in(b_in), .zeta_in(zeta_in), .out_valid(out_valid),
        .out_ready(out_ready), .a_out(a_out), .b_out(b_out), .mode_err(mode_err)
    );

    kyber_bf_unit #(.Q(Q), .W(W), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .mode(mode4),
        .a_in(a_in4), .b_in(b_in4), .zeta_in(zeta_in4), .out_valid(out_valid4),
        .out_ready(out_ready4), .a_out(a_out4), .b_out(b_out4), .mode_err(mode_err4)
    );

    // Reference butterfly; halving done as multiplication by 2^-1 = 1665 mod Q.
    function automatic void ref_bf(input int m, input int a, input int b, input int z,
                                   output int ea, output int eb);
        int t, d;
        case (m)
            0: begin
                t  = (b * z) % Q;
                ea = (a + t) % Q;
                eb = (a - t + Q) % Q;
            end
            1, 2: begin
                ea = (a + b) % Q;
                d  = (a - b + Q) % Q;
                eb = (d * z) % Q;
                if (m == 2) begin
                    ea = (ea * 1665) % Q;
                    eb = (eb * 1665) % Q;
                end
            end
            default: begin
                ea = a;
                eb = b;
            end
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_out !== '0 || b_out !== '0 ||
            mode_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b rdy=%b a=%0d b=%0d err=%b, want 0 1 0 0 0",
                     out_valid, in_ready, a_out, b_out, mode_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_math();
        string nm [5] = '{"ct_basic", "gs_basic", "gs_half", "ct_wrap", "gs_wrap"};
        int    vm [5] = '{0, 1, 2, 0, 1};
        int    va [5] = '{1, 5, 5, 3328, 0};
        int    vb [5] = '{2, 10, 10, 3328, 3328};
        int    vz [5] = '{17, 17, 17, 3328, 1};
        int    xa [5] = '{35, 15, 1672, 0, 3328};
        int    xb [5] = '{3296, 3244, 1622, 3327, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            mode      = 2'(vm[i]);
            a_in      = W'(va[i]);
            b_in      = W'(vb[i]);
            zeta_in   = W'(vz[i]);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_early: out_valid=%b after 2 cycles, want 0", nm[i], out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || a_out !== W'(xa[i]) || b_out !== W'(xb[i])) begin
                miscompares++;
                $display("FAIL %s: got v=%b a=%0d b=%0d, want v=1 a=%0d b=%0d",
                         nm[i], out_valid, a_out, b_out, xa[i], xb[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int           k_in = 0;
        int           k_out = 0;
        bit           stalled = 1'b0;
        logic [W-1:0] held_a = '0;
        int           stale = 0;
        for (int cyc = 0; cyc < 200 && k_out < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (k_in < 8);
            mode      = 2'd0;
            a_in      = W'(k_in);
            b_in      = '0;
            zeta_in   = W'(1);
            #1;
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || a_out !== held_a) begin
                    miscompares++;
                    $display("FAIL bp_hold: got v=%b a=%0d, want v=1 a=%0d",
                             out_valid, a_out, held_a);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_in_ready: got %b, want 0", in_ready);
                end
                held_a  = a_out;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                if (a_out !== W'(k_out)) begin
                    miscompares++;
                    $display("FAIL bp_order: got a=%0d, want %0d", a_out, k_out);
                end
                k_out++;
            end
            if (in_valid && in_ready === 1'b1) k_in++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        vectors++;
        if (k_out != 8 || stale != 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats and %0d extra, want 8 and 0", k_out, stale);
        end
    endtask

    task automatic test_throughput();
        int q_a [$];
        int q_b [$];
        int q_c [$];
        int sent = 0;
        int got = 0;
        int m, a, b, z, ea, eb, ga, gb, gc;
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 100) begin
                m = int'($urandom_range(0, 2));
                a = int'($urandom_range(0, Q - 1));
                b = int'($urandom_range(0, Q - 1));
                z = int'($urandom_range(0, Q - 1));
                in_valid = 1'b1;
                mode     = 2'(m);
                a_in     = W'(a);
                b_in     = W'(b);
                zeta_in  = W'(z);
                ref_bf(m, a, b, z, ea, eb);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                vectors++;
                if (q_a.size() == 0) begin
                    miscompares++;
                    $display("FAIL tp_spurious: got a=%0d b=%0d, want no beat", a_out, b_out);
                end else begin
                    ga = q_a.pop_front();
                    gb = q_b.pop_front();
                    gc = q_c.pop_front();
                    if (a_out !== W'(ga) || b_out !== W'(gb) || cyc - gc != 3) begin
                        miscompares++;
                        $display("FAIL tp_beat%0d: got a=%0d b=%0d lat=%0d, want a=%0d b=%0d lat=3",
                                 got, a_out, b_out, cyc - gc, ga, gb);
                    end
                end
                got++;
            end
            if (in_valid) begin
                if (in_ready === 1'b1) begin
                    q_a.push_back(ea);
                    q_b.push_back(eb);
                    q_c.push_back(cyc);
                    sent++;
                end else begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tp_in_ready: got %b, want 1", in_ready);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (got != 100) begin
            miscompares++;
            $display("FAIL tp_count: got %0d results, want 100", got);
        end
    endtask

    task automatic test_lanes();
        int           xa [4] = '{35, 0, 100, 3010};
        int           xb [4] = '{3296, 3327, 100, 339};
        logic [W-1:0] la, lb;
        @(negedge clk);
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        mode4      = 2'd0;
        a_in4      = {W'(10), W'(100), W'(3328), W'(1)};
        b_in4      = {W'(3), W'(0), W'(3328), W'(2)};
        zeta_in4   = {W'(1000), W'(5), W'(3328), W'(17)};
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            la = a_out4[i*W +: W];
            lb = b_out4[i*W +: W];
            vectors++;
            if (out_valid4 !== 1'b1 || la !== W'(xa[i]) || lb !== W'(xb[i])) begin
                miscompares++;
                $display("FAIL lane%0d: got v=%b a=%0d b=%0d, want v=1 a=%0d b=%0d",
                         i, out_valid4, la, lb, xa[i], xb[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mode3_reset();
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = 2'd3;
        a_in      = W'(7);
        b_in      = W'(9);
        zeta_in   = W'(0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || a_out !== W'(7) || b_out !== W'(9) || mode_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass: got v=%b a=%0d b=%0d err=%b, want v=1 a=7 b=9 err=1",
                     out_valid, a_out, b_out, mode_err);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (mode_err !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_err_hold: got %b, want 1", mode_err);
        end
        // Two CT beats enter, then reset lands before either can reach the output.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            mode     = 2'd0;
            a_in     = W'(20 + i);
            b_in     = W'(1);
            zeta_in  = W'(1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_out !== '0 || b_out !== '0 ||
            mode_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b rdy=%b a=%0d b=%0d err=%b, want 0 1 0 0 0",
                     out_valid, in_ready, a_out, b_out, mode_err);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL stale_beat: got %0d emitted beats after reset, want 0", stale);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        mode       = 2'd0;
        a_in       = '0;
        b_in       = '0;
        zeta_in    = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        mode4      = 2'd0;
        a_in4      = '0;
        b_in4      = '0;
        zeta_in4   = '0;
        test_reset();
        test_math();
        test_backpressure();
        test_throughput();
        test_lanes();
        test_mode3_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kyber_bf_unit.md
Name: kyber_bf_unit

Overview:
- Parametrised, pipelined, multi-lane modular butterfly for the Kyber NTT/INTT datapath.
- Supersedes the fixed single-mode butterflies with one block that executes Cooley-Tukey (forward) and Gentleman-Sande (inverse) butterflies, with optional INTT halving.
- Uses a valid/ready handshake with full backpressure.
- Sits between the coefficient-memory read port and the write-back path of the NTT controller.

Parameters:
- Q, 3329: modulus; must be odd and < 2^W.
- W, 12: coefficient width in bits.
- LANES, 1: number of parallel butterflies sharing one handshake and one mode.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- mode  in  2  0=CT, 1=GS, 2=GS_HALF, 3=BYPASS; sampled with the beat.
- a_in  in  LANES*W  lane i occupies bits [i*W +: W].
- b_in  in  LANES*W  second operand per lane.
- zeta_in  in  LANES*W  twiddle per lane.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the beat.
- a_out  out  LANES*W  first result per lane.
- b_out  out  LANES*W  second result per lane.
- mode_err  out  1  sticky; set when a beat with mode=3 is accepted.

Behaviour:
- Arithmetic, per lane, with all results canonical in [0, Q-1]:
  - CT: t=b*zeta mod Q; a'=(a+t) mod Q; b'=(a-t) mod Q.
  - GS: a'=(a+b) mod Q; b'=((a-b) mod Q)*zeta mod Q.
  - GS_HALF: GS results each multiplied by 2^-1 mod Q: x even -> x/2; x odd -> (x+Q)/2.
  - BYPASS: a'=a, b'=b.
- Operands a_in, b_in and zeta_in >= Q are out of contract. Outputs for them are deterministic but unspecified. Benches do not drive them.
- Pipeline, 3 register stages; latency is exactly 3 cycles from accept to out_valid when unstalled, independent of mode:
  - S1: capture operands and mode; GS pre-add/sub with conditional +Q/-Q correction.
  - S2: 2W-bit product (b*zeta for CT, diff*zeta for GS).
  - S3: Barrett reduction, CT post-add/sub, halving, output register.
- Handshake:
  - adv = out_ready | ~out_valid; in_ready = adv.
  - Accept happens when in_valid & in_ready.
  - All stages shift together when adv=1 and hold when adv=0.
  - Per-stage valid bits; bubbles propagate as invalid stages.
  - Throughput is one beat per cycle under continuous out_ready=1.
- Outputs are stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0 at a clock edge), including mid-stream:
  - All stage valids cleared; out_valid=0, in_ready=1.
  - a_out=0, b_out=0, mode_err=0.
  - In-flight beats are discarded, not emitted.
- mode_err clears only on reset.
- Simultaneous accept and emit in one cycle is legal and lossless.

Decomposition:
- Package kyber_pkg holds:
  - Q, W, the mode encodings (CT, GS, GS_HALF, BYPASS).
  - BARRETT_K = 2*W and BARRETT_M = floor(2^BARRETT_K / Q), computed by a package function; 5039 for the defaults.
  - INV2 = (Q+1)/2.
- Sub-module kyber_mod_mul_q performs Barrett reduction: input x < Q^2; r = x - ((x*BARRETT_M) >> BARRETT_K)*Q, then one conditional subtract of Q. Purely combinational; instantiated once per lane in S3.

Test Plan:
- Single-beat math (Q=3329, LANES=1), each result exactly 3 cycles after accept:
  - CT a=1, b=2, zeta=17 -> a'=35, b'=3296.
  - GS a=5, b=10, zeta=17 -> a'=15, b'=3244.
  - GS_HALF same inputs -> a'=1672, b'=1622.
- Wrap boundary: CT a=3328, b=3328, zeta=3328 -> a'=0, b'=3327. GS a=0, b=3328, zeta=1 -> a'=3328, b'=1.
- Backpressure: stream 8 beats CT a=k, b=0, zeta=1 (k=0..7) while toggling out_ready 1,0,0,1,... -> emitted a' sequence 0..7 in order, no loss or duplication, outputs stable while stalled; in_ready=0 whenever out_valid=1 and out_ready=0.
- Full throughput: out_ready=1, 100 back-to-back random beats in random modes 0-2 -> 100 results matching the reference model, one per cycle after 3-cycle fill.
- LANES=4 build: distinct per-lane operands, CT -> each lane matches the model independently.
- Mode 3 and reset:
  - Accept mode=3 with a=7, b=9 -> a'=7, b'=9, mode_err=1 and held.
  - Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat ever emitted, mode_err=0.
